// File: rtl/video_line_fifo_if.sv
`default_nettype none
// ============================================================================
// Interface : video_line_fifo_if
// Write stream, read stream and status of the video line FIFO.
// Revision  : 1.0
// ============================================================================
interface video_line_fifo_if #(
    parameter int DATA_W = 8,
    parameter int LINES  = 5
);
    localparam int CNT_W = $clog2(LINES + 1);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_sop;
    logic              in_eop;
    logic              in_ready;

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_sop;
    logic              out_eop;
    logic              out_ready;

    logic [CNT_W-1:0]  line_count;
    logic              full;
    logic              empty;
    logic [15:0]       drop_count;

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, out_ready,
        output in_ready, out_data, out_valid, out_sop, out_eop,
        output line_count, full, empty, drop_count
    );

    modport master (
        output in_data, in_valid, in_sop, in_eop, out_ready,
        input  in_ready, out_data, out_valid, out_sop, out_eop,
        input  line_count, full, empty, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/video_line_fifo.sv
`default_nettype none
// ============================================================================
// Module   : video_line_fifo
// Line-granular store-and-forward FIFO; a line is readable once its eop lands.
// Revision : 1.0
// ============================================================================
module video_line_fifo #(
    parameter int DATA_W   = 8,
    parameter int LINE_LEN = 1440,
    parameter int LINES    = 5
) (
    input  logic                clock,
    input  logic                reset,
    video_line_fifo_if.slave    bus
);
    localparam int DEPTH  = LINES * LINE_LEN;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOT_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int LEN_W  = $clog2(LINE_LEN + 1);
    localparam int CNT_W  = $clog2(LINES + 1);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DROP = 2'd2
    } wr_state_t;

    wr_state_t         r_state;
    logic [LEN_W-1:0]  r_wr_col;
    logic [SLOT_W-1:0] r_wr_slot;
    logic              r_in_ready;
    logic              r_orphan;
    logic [CNT_W-1:0]  r_line_count;
    logic [CNT_W-1:0]  r_fetch_lines;
    logic [15:0]       r_drop_count;
    logic [LEN_W-1:0]  r_len [LINES];
    logic [DATA_W-1:0] mem [DEPTH];

    logic [SLOT_W-1:0] r_rd_slot;
    logic [LEN_W-1:0]  r_rd_col;
    logic              r_pend;
    logic              r_pend_sop;
    logic              r_pend_eop;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_sk_data [2];
    logic [1:0]        r_sk_sop;
    logic [1:0]        r_sk_eop;
    logic [1:0]        r_sk_cnt;

    logic              w_acc, w_wr_en, w_commit, w_drop, w_next_idle;
    logic              w_pop, w_free, w_fetch, w_fetch_eop, w_push_hi;
    logic [LEN_W-1:0]  w_wcol, w_commit_len;
    logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [2:0]        w_occ;

    always_comb begin
        w_acc        = bus.in_valid & r_in_ready;
        w_wr_en      = 1'b0;
        w_commit     = 1'b0;
        w_drop       = 1'b0;
        w_wcol       = bus.in_sop ? '0 : r_wr_col;
        w_commit_len = bus.in_sop ? LEN_W'(1) : r_wr_col + LEN_W'(1);
        if (w_acc) begin
            if (bus.in_sop) begin
                w_wr_en  = 1'b1;
                w_commit = bus.in_eop;
                w_drop   = (r_state == W_FILL);
            end else begin
                case (r_state)
                    W_IDLE: w_drop = !r_orphan;
                    W_FILL: begin
                        if (r_wr_col < LEN_W'(LINE_LEN)) begin
                            w_wr_en  = 1'b1;
                            w_commit = bus.in_eop;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        w_next_idle = w_acc ? (bus.in_eop || (r_state == W_IDLE && !bus.in_sop))
                            : (r_state == W_IDLE);
    end

    assign w_wr_addr   = ADDR_W'(r_wr_slot) * ADDR_W'(LINE_LEN) + ADDR_W'(w_wcol);
    assign w_rd_addr   = ADDR_W'(r_rd_slot) * ADDR_W'(LINE_LEN) + ADDR_W'(r_rd_col);
    assign w_pop       = (r_sk_cnt != 2'd0) & bus.out_ready;
    assign w_free      = w_pop & r_sk_eop[0];
    // Occupancy counts the in-flight RAM read so the skid can never overflow.
    assign w_occ       = {1'b0, r_sk_cnt} + {2'b0, r_pend} - {2'b0, w_pop};
    assign w_fetch     = (r_fetch_lines != '0) && (w_occ < 3'd2);
    assign w_fetch_eop = (r_rd_col + LEN_W'(1)) == r_len[r_rd_slot];
    assign w_push_hi   = (r_sk_cnt == 2'd2) || ((r_sk_cnt == 2'd1) && !w_pop);
    assign w_count_nxt = r_line_count + CNT_W'(w_commit) - CNT_W'(w_free);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= W_IDLE;
            r_wr_col   <= '0;
            r_wr_slot  <= '0;
            r_in_ready <= 1'b0;
            r_orphan   <= 1'b0;
        end else begin
            // Slot is already reserved outside W_IDLE, so only idle entry waits on space.
            r_in_ready <= !w_next_idle || (w_count_nxt != CNT_W'(LINES));
            if (w_acc) begin
                r_orphan <= (r_state == W_IDLE) && !bus.in_sop && !bus.in_eop;
                if (bus.in_sop) begin
                    r_wr_col <= LEN_W'(1);
                    r_state  <= bus.in_eop ? W_IDLE : W_FILL;
                end else begin
                    case (r_state)
                        W_FILL: begin
                            if (bus.in_eop)
                                r_state <= W_IDLE;
                            else if (r_wr_col < LEN_W'(LINE_LEN))
                                r_wr_col <= r_wr_col + LEN_W'(1);
                            else
                                r_state <= W_DROP;
                        end
                        W_DROP: if (bus.in_eop) r_state <= W_IDLE;
                        default: ;
                    endcase
                end
            end
            if (w_commit)
                r_wr_slot <= (r_wr_slot == SLOT_W'(LINES - 1)) ? '0 : r_wr_slot + SLOT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_line_count  <= '0;
            r_fetch_lines <= '0;
            r_drop_count  <= '0;
        end else begin
            r_line_count  <= w_count_nxt;
            r_fetch_lines <= r_fetch_lines + CNT_W'(w_commit) - CNT_W'(w_fetch & w_fetch_eop);
            if (w_drop && r_drop_count != 16'hFFFF)
                r_drop_count <= r_drop_count + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en)
            mem[w_wr_addr] <= bus.in_data;
        if (w_commit)
            r_len[r_wr_slot] <= w_commit_len;
        if (w_fetch)
            r_rd_data <= mem[w_rd_addr];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_slot    <= '0;
            r_rd_col     <= '0;
            r_pend       <= 1'b0;
            r_pend_sop   <= 1'b0;
            r_pend_eop   <= 1'b0;
            r_sk_data[0] <= '0;
            r_sk_data[1] <= '0;
            r_sk_sop     <= '0;
            r_sk_eop     <= '0;
            r_sk_cnt     <= '0;
        end else begin
            r_pend <= w_fetch;
            if (w_fetch) begin
                r_pend_sop <= (r_rd_col == '0);
                r_pend_eop <= w_fetch_eop;
                if (w_fetch_eop) begin
                    r_rd_col  <= '0;
                    r_rd_slot <= (r_rd_slot == SLOT_W'(LINES - 1)) ? '0 : r_rd_slot + SLOT_W'(1);
                end else begin
                    r_rd_col <= r_rd_col + LEN_W'(1);
                end
            end
            if (w_pop) begin
                r_sk_data[0] <= r_sk_data[1];
                r_sk_sop[0]  <= r_sk_sop[1];
                r_sk_eop[0]  <= r_sk_eop[1];
            end
            // The push lands after the shift so it wins when both target entry 0.
            if (r_pend) begin
                if (w_push_hi) begin
                    r_sk_data[1] <= r_rd_data;
                    r_sk_sop[1]  <= r_pend_sop;
                    r_sk_eop[1]  <= r_pend_eop;
                end else begin
                    r_sk_data[0] <= r_rd_data;
                    r_sk_sop[0]  <= r_pend_sop;
                    r_sk_eop[0]  <= r_pend_eop;
                end
            end
            r_sk_cnt <= r_sk_cnt + {1'b0, r_pend} - {1'b0, w_pop};
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = (r_sk_cnt != 2'd0);
    assign bus.out_data   = r_sk_data[0];
    assign bus.out_sop    = r_sk_sop[0];
    assign bus.out_eop    = r_sk_eop[0];
    assign bus.line_count = r_line_count;
    assign bus.full       = (r_line_count == CNT_W'(LINES));
    assign bus.empty      = (r_line_count == '0);
    assign bus.drop_count = r_drop_count;
endmodule
`default_nettype wire

// File: tb/tb_video_line_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_line_fifo
// Scoreboard bench for video_line_fifo with LINE_LEN=8, LINES=2.
// Revision : 1.0
// ============================================================================
module tb_video_line_fifo;
    localparam int DATA_W   = 8;
    localparam int LINE_LEN = 8;
    localparam int LINES    = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    video_line_fifo_if #(.DATA_W(DATA_W), .LINES(LINES)) bus ();

    video_line_fifo #(
        .DATA_W  (DATA_W),
        .LINE_LEN(LINE_LEN),
        .LINES   (LINES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    logic bp_en     = 1'b0;
    logic bp_rand   = 1'b0;
    logic ready_cmd = 1'b0;
    assign bus.out_ready = bp_en ? bp_rand : ready_cmd;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    bit    mon_stall = 1'b0;
    beat_t mon_held;
    beat_t mon_cur;
    beat_t mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic put(input logic [7:0] d, input logic s, input logic e);
        int waited;
        bit acc;
        waited = 0;
        acc    = 1'b0;
        bus.in_data  = d;
        bus.in_sop   = s;
        bus.in_eop   = e;
        bus.in_valid = 1'b1;
        while (!acc && waited < 200) begin
            @(negedge clock);
            acc = bus.in_ready;
            @(posedge clock);
            #1;
            waited++;
        end
        bus.in_valid = 1'b0;
        chk("put_accepted", 32'(acc), 32'd1);
    endtask

    task automatic send_line(input logic [7:0] base, input int len, input bit keep);
        for (int i = 0; i < len; i++) begin
            logic [7:0] d;
            d = base + 8'(i);
            if (keep) sb.push_back({d, (i == 0), (i == len - 1)});
            put(d, (i == 0), (i == len - 1));
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !bus.empty || bus.out_valid) && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("drain_done", 32'(sb.size() == 0 && bus.empty && !bus.out_valid), 32'd1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            bp_rand = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    initial begin
        forever begin
            @(negedge clock);
            mon_cur = {bus.out_data, bus.out_sop, bus.out_eop};
            if (reset) begin
                mon_stall = 1'b0;
            end else begin
                if (mon_stall) begin
                    chk("out_valid_held", 32'(bus.out_valid), 32'd1);
                    chk("out_stable", 32'(mon_cur), 32'(mon_held));
                end
                if (bus.out_valid && bus.out_ready) begin
                    chk("beat_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        mon_exp = sb.pop_front();
                        chk("out_beat", 32'(mon_cur), 32'(mon_exp));
                    end
                end
                mon_stall = bus.out_valid && !bus.out_ready;
                mon_held  = mon_cur;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  lat;
        bit  found;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_sop_eop", 32'({bus.out_sop, bus.out_eop}), 32'd0);
        chk("rst_line_count", 32'(bus.line_count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_drop_count", 32'(bus.drop_count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycles(2);
        @(negedge clock);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clock);
        #1;

        // Single 4-beat line, free-running reader
        ready_cmd = 1'b1;
        send_line(8'h01, 4, 1'b1);
        lat = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            if (i == 1) chk("line_count_after_commit", 32'(bus.line_count), 32'd1);
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        chk("first_beat_latency_le3", 32'(lat >= 1 && lat <= 3), 32'd1);
        @(posedge clock);
        #1;
        wait_drain();
        chk("line_count_after_read", 32'(bus.line_count), 32'd0);

        // Fill both slots with the reader stalled
        ready_cmd = 1'b0;
        send_line(8'h10, 3, 1'b1);
        send_line(8'h20, 2, 1'b1);
        cycles(2);
        @(negedge clock);
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_line_count", 32'(bus.line_count), 32'd2);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fill_empty", 32'(bus.empty), 32'd0);
        @(posedge clock);
        #1;
        ready_cmd = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.out_valid && bus.out_ready && bus.out_eop) begin
                found = 1'b1;
                break;
            end
        end
        chk("first_eop_handshake_seen", 32'(found), 32'd1);
        @(negedge clock);
        chk("free_in_ready", 32'(bus.in_ready), 32'd1);
        chk("free_line_count", 32'(bus.line_count), 32'd1);
        chk("free_full", 32'(bus.full), 32'd0);
        @(posedge clock);
        #1;
        wait_drain();

        // Over-length line dropped, then a maximum-length line passes
        chk("drop_count_before", 32'(bus.drop_count), 32'd0);
        put(8'h30, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) put(8'h30 + 8'(i), 1'b0, 1'b0);
        put(8'h39, 1'b0, 1'b1);
        send_line(8'h40, 8, 1'b1);
        wait_drain();
        chk("drop_count_overlength", 32'(bus.drop_count), 32'd1);

        // sop in mid-line restarts the line
        put(8'h50, 1'b1, 1'b0);
        put(8'h51, 1'b0, 1'b0);
        sb.push_back({8'h52, 1'b1, 1'b0});
        put(8'h52, 1'b1, 1'b0);
        sb.push_back({8'h53, 1'b0, 1'b1});
        put(8'h53, 1'b0, 1'b1);
        wait_drain();
        chk("drop_count_mid_sop", 32'(bus.drop_count), 32'd2);

        // Orphan beats while idle: one drop per run, then a 1-beat line
        put(8'h60, 1'b0, 1'b0);
        put(8'h61, 1'b0, 1'b0);
        put(8'h62, 1'b0, 1'b1);
        put(8'h63, 1'b0, 1'b0);
        sb.push_back({8'h70, 1'b1, 1'b1});
        put(8'h70, 1'b1, 1'b1);
        wait_drain();
        chk("drop_count_orphans", 32'(bus.drop_count), 32'd4);

        // Random backpressure across several lines
        bp_en = 1'b1;
        send_line(8'hB0, 3, 1'b1);
        send_line(8'hC0, 8, 1'b1);
        send_line(8'hD0, 1, 1'b1);
        send_line(8'hE0, 5, 1'b1);
        wait_drain();
        bp_en = 1'b0;

        // Reset during a write and a partial read
        ready_cmd = 1'b0;
        send_line(8'hF0, 5, 1'b1);
        cycles(3);
        ready_cmd = 1'b1;
        cycles(2);
        ready_cmd = 1'b0;
        put(8'h90, 1'b1, 1'b0);
        put(8'h91, 1'b0, 1'b0);
        bus.in_data  = 8'h92;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_valid = 1'b1;
        reset = 1'b1;
        sb.delete();
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clock);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_line_count", 32'(bus.line_count), 32'd0);
        chk("midrst_empty", 32'(bus.empty), 32'd1);
        chk("midrst_drop_count", 32'(bus.drop_count), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        ready_cmd = 1'b1;
        send_line(8'hA0, 2, 1'b1);
        wait_drain();
        chk("post_rst_drop_count", 32'(bus.drop_count), 32'd0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
